// File: rtl/hw_sequencer.sv
// Microprogram-free beat sequencer for a teaching-computer datapath.
// Generates one-hot W1/W2/W3 beats and decodes console modes and exec
// opcodes into datapath strobes. All state moves on the falling edge of t3.
module hw_sequencer #(
  parameter int  NREG     = 4,
  parameter bit  MEM_WAIT = 1'b0,
  localparam int RW       = $clog2(NREG)
) (
  input  logic          t3,
  input  logic          clr,
  input  logic [2:0]    sw,
  input  logic          run,
  input  logic          step,
  input  logic [3:0]    ir,
  input  logic          c,
  input  logic          z,
  output logic          w1,
  output logic          w2,
  output logic          w3,
  output logic          st0,
  output logic          halted,
  output logic [RW-1:0] sel_a,
  output logic [RW-1:0] sel_b,
  output logic          drw,
  output logic          pcinc,
  output logic          lpc,
  output logic          lar,
  output logic          pcadd,
  output logic          arinc,
  output logic          selctl,
  output logic          memw,
  output logic          lir,
  output logic          ldz,
  output logic          ldc,
  output logic          cin,
  output logic          m,
  output logic          abus,
  output logic          sbus,
  output logic          mbus,
  output logic [3:0]    s
);

  typedef enum logic [1:0] {
    BEAT_IDLE = 2'd0,
    BEAT_W1   = 2'd1,
    BEAT_W2   = 2'd2,
    BEAT_W3   = 2'd3
  } beat_e;

  localparam logic [2:0] MODE_EXEC = 3'b000;
  localparam logic [2:0] MODE_WMEM = 3'b001;
  localparam logic [2:0] MODE_RMEM = 3'b010;
  localparam logic [2:0] MODE_RREG = 3'b011;
  localparam logic [2:0] MODE_WREG = 3'b100;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_LD  = 4'b0101;
  localparam logic [3:0] OP_ST  = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_DEC = 4'b1011;
  localparam logic [3:0] OP_STP = 4'b1110;

  beat_e         beat_q, beat_d;
  logic          st0_q;
  logic [RW-1:0] ridx_q;
  logic [2:0]    mode_q;
  logic          br_q;

  logic          stop, last, set_st0, fetch, alu;
  logic          flag_now, taken;
  logic [RW-1:0] ridx_adv;

  assign w1     = (beat_q == BEAT_W1);
  assign w2     = (beat_q == BEAT_W2);
  assign w3     = (beat_q == BEAT_W3);
  assign halted = (beat_q == BEAT_IDLE);
  assign st0    = st0_q;

  // Beat register; clr drops it to IDLE immediately, even mid-step.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) beat_q <= BEAT_IDLE;
    else      beat_q <= beat_d;
  end

  // Strobe decode and next-beat selection.
  // NOTE: every signal gets a default before any branch so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    {drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw} = 8'b0;
    {lir, ldz, ldc, cin, m, abus, sbus, mbus}          = 8'b0;
    s        = 4'b0000;
    sel_a    = '0;
    sel_b    = '0;
    stop     = 1'b0;
    last     = 1'b1;
    set_st0  = 1'b0;
    fetch    = 1'b0;
    alu      = 1'b0;
    ridx_adv = '0;
    flag_now = (ir == OP_JZ) ? z : c;
    taken    = (beat_q == BEAT_W1) ? flag_now : br_q;
    beat_d   = beat_q;

    if (beat_q != BEAT_IDLE) begin
      case (mode_q)
        MODE_WREG: begin
          sbus = 1'b1; selctl = 1'b1; drw = 1'b1; stop = 1'b1;
          sel_a    = ridx_q;
          ridx_adv = RW'(1);
        end
        MODE_RREG: begin
          selctl = 1'b1; stop = 1'b1;
          sel_a    = ridx_q;
          sel_b    = ridx_q + RW'(1);
          ridx_adv = RW'(2);
        end
        MODE_RMEM, MODE_WMEM: begin
          selctl = 1'b1; stop = 1'b1;
          if (!st0_q) begin
            sbus = 1'b1; lar = 1'b1; set_st0 = 1'b1;
          end else begin
            arinc = 1'b1;
            if (mode_q == MODE_RMEM) mbus = 1'b1;
            else begin sbus = 1'b1; memw = 1'b1; end
          end
        end
        MODE_EXEC: begin
          if (!st0_q) begin
            sbus = 1'b1; lpc = 1'b1; stop = 1'b1; set_st0 = 1'b1;
          end else begin
            case (ir)
              OP_ADD: begin alu = 1'b1; s = 4'b1001; cin = 1'b1; ldc = 1'b1; end
              OP_SUB: begin alu = 1'b1; s = 4'b0110; ldc = 1'b1; end
              OP_AND: begin alu = 1'b1; s = 4'b1011; m = 1'b1; end
              OP_INC: begin alu = 1'b1; s = 4'b0000; ldc = 1'b1; end
              OP_XOR: begin alu = 1'b1; s = 4'b0110; m = 1'b1; end
              OP_DEC: begin alu = 1'b1; s = 4'b1111; cin = 1'b1; ldc = 1'b1; end
              OP_LD: begin
                case (beat_q)
                  BEAT_W1: begin s = 4'b1010; m = 1'b1; abus = 1'b1; lar = 1'b1; last = 1'b0; end
                  BEAT_W2: begin mbus = 1'b1; drw = 1'b1; fetch = ~MEM_WAIT; last = ~MEM_WAIT; end
                  default: fetch = 1'b1;
                endcase
              end
              OP_ST: begin
                case (beat_q)
                  BEAT_W1: begin s = 4'b1111; m = 1'b1; abus = 1'b1; lar = 1'b1; last = 1'b0; end
                  BEAT_W2: begin
                    s = 4'b1010; m = 1'b1; abus = 1'b1; memw = 1'b1;
                    fetch = ~MEM_WAIT; last = ~MEM_WAIT;
                  end
                  default: fetch = 1'b1;
                endcase
              end
              OP_JC, OP_JZ: begin
                if (beat_q == BEAT_W1 && taken) begin pcadd = 1'b1; last = 1'b0; end
                else fetch = 1'b1;
              end
              OP_JMP: begin
                if (beat_q == BEAT_W1) begin
                  s = 4'b1111; m = 1'b1; abus = 1'b1; lpc = 1'b1; last = 1'b0;
                end else fetch = 1'b1;
              end
              OP_STP:  stop  = 1'b1;
              default: fetch = 1'b1;
            endcase
          end
        end
        default: stop = 1'b1;
      endcase
    end

    if (alu) begin
      abus = 1'b1; drw = 1'b1; ldz = 1'b1; fetch = 1'b1;
    end
    lir   = fetch;
    pcinc = fetch;

    case (beat_q)
      BEAT_IDLE: if (run) beat_d = BEAT_W1;
      default: begin
        if (last)
          beat_d = (stop || (step && mode_q == MODE_EXEC && st0_q)) ? BEAT_IDLE : BEAT_W1;
        else
          beat_d = (beat_q == BEAT_W1) ? BEAT_W2 : BEAT_W3;
      end
    endcase
  end

  // Mode phase, register index, stored console mode and branch latch.
  // NOTE: all of these are control state, so each is cleared by clr; there is
  // no memory array here that could be left unreset.
  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) begin
      st0_q  <= 1'b0;
      ridx_q <= '0;
      mode_q <= MODE_EXEC;
      br_q   <= 1'b0;
    end else if (beat_q == BEAT_IDLE) begin
      mode_q <= sw;
      if (sw != mode_q) begin
        st0_q  <= 1'b0;
        ridx_q <= '0;
      end
    end else if (beat_q == BEAT_W1) begin
      if (set_st0) st0_q <= 1'b1;
      ridx_q <= ridx_q + ridx_adv;
      br_q   <= flag_now;
    end
  end

endmodule

// File: doc/hw_sequencer.md
HW_SEQUENCER -- requirements
Module: hw_sequencer

Interface
REQ-001 NREG, 4, register-file size; power of two, 4..16; RW = log2(NREG).
REQ-002 MEM_WAIT, 0, 1 = LD/ST take an extra W3 beat for slow memory.
REQ-003 t3  input  1  clock; one clock; all state updates on falling edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 sw  input  3  console mode {swc,swb,swa}.
REQ-006 run  input  1  start/continue request, sampled only in IDLE.
REQ-007 step  input  1  single-instruction mode for exec.
REQ-008 ir  input  4  opcode; c, z  input  1 each  carry/zero flags.
REQ-009 w1, w2, w3  output  1 each  one-hot beat indicators.
REQ-010 st0  output  1  mode phase flag; halted  output  1  high in IDLE.
REQ-011 sel_a, sel_b  output  RW each  console register selects.
REQ-012 drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, lir, ldz, ldc, cin, m, abus, sbus, mbus  output  1 each  datapath strobes.
REQ-013 s  output  4  ALU function.

Function
REQ-014 Beat FSM: IDLE, W1, W2, W3; IDLE->W1 when run=1 at edge; w1/w2/w3 high in matching state only.
REQ-015 W1->W2 unless step is one-beat; W2->W3 only for LD/ST with MEM_WAIT=1; step ends after last beat.
REQ-016 End of step -> IDLE if stop asserted in last beat, or step=1 in exec with st0=1; else -> W1.
REQ-017 Strobes combinational from (beat, sw, st0, ir, latched branch flag); all 0 in IDLE; unlisted strobes 0.
REQ-018 Modes: sw=100 wreg, 011 rreg, 010 rmem, 001 wmem, 000 exec; others: W1 stop only.
REQ-019 sw registered in IDLE; differing from stored mode clears st0 and ridx before next step.
REQ-020 wreg: W1 sbus, selctl, drw, stop; sel_a=ridx; ridx <= ridx+1 mod NREG.
REQ-021 rreg: W1 selctl, stop; sel_a=ridx, sel_b=ridx+1 mod NREG; ridx <= ridx+2 mod NREG.
REQ-022 rmem: st0=0: W1 sbus, lar, selctl, stop, st0<=1; st0=1: W1 mbus, arinc, selctl, stop.
REQ-023 wmem: as rmem, st0=1 beat uses sbus, memw, arinc, selctl, stop.
REQ-024 exec st0=0: W1 sbus, lpc, stop; st0<=1.
REQ-025 exec st0=1, "fetch" = lir+pcinc; ALU ops one beat, W1 abus, drw, ldz, fetch plus:
REQ-026 ADD 0001 s=1001 cin ldc; SUB 0010 s=0110 ldc; AND 0011 s=1011 m; INC 0100 s=0000 ldc; XOR 1010 s=0110 m; DEC 1011 s=1111 cin ldc.
REQ-027 LD 0101: W1 s=1010 m abus lar; W2 mbus drw, fetch if MEM_WAIT=0; W3 fetch.
REQ-028 ST 0110: W1 s=1111 m abus lar; W2 s=1010 m abus memw, fetch if MEM_WAIT=0; W3 fetch.
REQ-029 JC 0111 / JZ 1000: flag sampled and latched at W1; false: W1 fetch, one beat; true: W1 pcadd, W2 fetch.
REQ-030 JMP 1001: W1 s=1111 m abus lpc; W2 fetch.
REQ-031 STP 1110: W1 stop; NOP 0000 and undefined 1100/1101/1111: W1 fetch.
REQ-032 sel_a=sel_b=0 outside wreg/rreg.
REQ-033 long never asserted; step length fixed by FSM only.

Reset
REQ-034 clr=0 forces IDLE, st0=0, ridx=0, stored mode=000, branch latch=0 immediately, mid-step included.
REQ-035 During/after reset: halted=1, w1..w3=0, s=0000, all strobes 0, sel_a=sel_b=0.
REQ-036 After clr rises, no beat until run=1 sampled.

Verification
REQ-037 NREG=8, sw=100, 9 run pulses -> sel_a 0..7 then 0, drw in each W1, halted after each.
REQ-038 sw=010: run, run, run -> lar at st0=0; then mbus+arinc twice; st0 stays 1; sw change in IDLE -> st0=0.
REQ-039 exec, ir=0111: c=1 -> W1 pcadd, W2 lir; c=0 -> W1 lir+pcinc, next beat W1.
REQ-040 MEM_WAIT=1, ir=0101 -> W1 lar, W2 mbus+drw no lir, W3 lir+pcinc; MEM_WAIT=0 -> no W3.
REQ-041 exec, step=1, ir=0001 -> one W1 (s=1001, cin, drw), then IDLE until run.
REQ-042 clr low during W2 of ST -> memw drops asynchronously, IDLE, st0=0.
